// File: rtl/cordic_log_scale.sv
// Post-scaler for the CORDIC log core: multiplies ln(x)/2 by a programmable
// fix32_24 coefficient, rounds, saturates and buffers results in a small FIFO.
module cordic_log_scale #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] COEF_RST = 32'h0200_0000
) (
   input  logic                     i_clk,
   input  logic                     i_arstn,
   input  logic                     i_valid,
   input  logic [31:0]              i_data,
   input  logic                     i_coef_we,
   input  logic [31:0]              i_coef,
   input  logic                     i_flag_clr,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [31:0]              o_data,
   output logic                     o_overflow,
   output logic                     o_sat,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]        coef_q;
   logic signed [63:0] p1_d, p1_q;
   logic               v1_q;

   logic signed [63:0] r_full;
   logic               clamp_hi, clamp_lo;
   logic [31:0]        res_d, res_q;
   logic               v2_q;

   logic [31:0]        mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      count_q, count_d;
   logic               full, rd_en, wr_en, drop;
   logic               sat_q, ovf_q;

   // Full-precision Q16.48 product of sample and the coefficient held before this edge
   always_comb begin
      p1_d = $signed({{32{i_data[31]}}, i_data}) * $signed({{32{coef_q[31]}}, coef_q});
   end

   // Stage 1: coefficient register and multiplier pipeline register
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         coef_q <= COEF_RST;
         p1_q   <= '0;
         v1_q   <= 1'b0;
      end else begin
         if (i_coef_we) coef_q <= i_coef;
         v1_q <= i_valid;
         if (i_valid) p1_q <= p1_d;
      end
   end

   // Round half up back to fix32_24 and clamp to the signed 32-bit range
   always_comb begin
      r_full   = (p1_q + 64'sd8388608) >>> 24;
      clamp_hi = !r_full[63] && (|r_full[62:31]);
      clamp_lo = r_full[63] && !(&r_full[62:31]);
      res_d    = r_full[31:0];
      if (clamp_hi) res_d = 32'h7FFF_FFFF;
      if (clamp_lo) res_d = 32'h8000_0000;
   end

   // Stage 2: registered, saturated result awaiting FIFO write
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         res_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) res_q <= res_d;
      end
   end

   // FIFO handshake decode; a read at full frees the slot the write lands in
   always_comb begin
      full    = (count_q == CW'(DEPTH));
      rd_en   = o_valid && i_ready;
      wr_en   = v2_q && (!full || rd_en);
      drop    = v2_q && full && !rd_en;
      count_d = count_q;
      unique case ({wr_en, rd_en})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage, power-of-two pointers wrap naturally
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= res_q;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Sticky flags; a set event on the clearing edge wins
   always_ff @(posedge i_clk or negedge i_arstn) begin
      if (!i_arstn) begin
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         sat_q <= (v1_q && (clamp_hi || clamp_lo)) || (sat_q && !i_flag_clr);
         ovf_q <= drop || (ovf_q && !i_flag_clr);
      end
   end

   // Output drive straight from registers
   always_comb begin
      o_valid    = (count_q != '0);
      o_data     = mem_q[rd_ptr_q];
      o_count    = count_q;
      o_overflow = ovf_q;
      o_sat      = sat_q;
   end

endmodule

// File: tb/tb_cordic_log_scale.sv
// Scoreboard bench for cordic_log_scale: expected results queued at stimulus time,
// popped and compared whenever the DUT hands a word to the consumer.
module tb_cordic_log_scale;

   localparam int unsigned DEPTH = 4;

   logic        i_clk = 1'b0;
   logic        i_arstn = 1'b0;
   logic        i_valid = 1'b0;
   logic [31:0] i_data = '0;
   logic        i_coef_we = 1'b0;
   logic [31:0] i_coef = '0;
   logic        i_flag_clr = 1'b0;
   logic        i_ready = 1'b0;
   logic        o_valid;
   logic [31:0] o_data;
   logic        o_overflow;
   logic        o_sat;
   logic [2:0]  o_count;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q [$];
   logic [31:0] coef_m = 32'h0200_0000;

   cordic_log_scale #(
      .DEPTH   (DEPTH),
      .COEF_RST(32'h0200_0000)
   ) u_dut (
      .i_clk     (i_clk),
      .i_arstn   (i_arstn),
      .i_valid   (i_valid),
      .i_data    (i_data),
      .i_coef_we (i_coef_we),
      .i_coef    (i_coef),
      .i_flag_clr(i_flag_clr),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_data    (o_data),
      .o_overflow(o_overflow),
      .o_sat     (o_sat),
      .o_count   (o_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] c);
      longint p, r;
      p = longint'($signed(d)) * longint'($signed(c));
      r = (p + 64'sd8388608) >>> 24;
      if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (r < -64'sd2147483648) return 32'h8000_0000;
      return r[31:0];
   endfunction

   // Consumer side: every accepted word must match the queue head
   always @(negedge i_clk) begin
      if (i_arstn && o_valid && i_ready) begin
         if (exp_q.size() == 0) check_eq("spurious_valid", {63'd0, o_valid}, 64'd0);
         else check_eq("data", {32'd0, o_data}, {32'd0, exp_q.pop_front()});
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [31:0] d, input logic [31:0] e, input bit push);
      i_valid = 1'b1;
      i_data  = d;
      if (push) exp_q.push_back(e);
      tick();
      i_valid = 1'b0;
   endtask

   task automatic write_coef(input logic [31:0] c);
      i_coef_we = 1'b1;
      i_coef    = c;
      coef_m    = c;
      tick();
      i_coef_we = 1'b0;
   endtask

   task automatic clear_flags();
      i_flag_clr = 1'b1;
      tick();
      i_flag_clr = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || o_valid) && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) check_eq({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
      check_eq({tag, "_count"}, {61'd0, o_count}, 64'd0);
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] c;

      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] c;

      // Reset state
      #12;
      check_eq("rst_valid", {63'd0, o_valid}, 64'd0);
      check_eq("rst_data", {32'd0, o_data}, 64'd0);
      check_eq("rst_ovf", {63'd0, o_overflow}, 64'd0);
      check_eq("rst_sat", {63'd0, o_sat}, 64'd0);
      check_eq("rst_count", {61'd0, o_count}, 64'd0);
      i_arstn = 1'b1;
      tick();

      // Default coefficient (ln) and single-cycle output pulse two edges after input
      i_ready = 1'b1;
      send(32'h0058_B90C, 32'h00B1_7218, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge i_clk);
         check_eq($sformatf("latency_%0d", k), {63'd0, o_valid}, {63'd0, (k == 2)});
         tick();
      end
      check_eq("sat_ln2", {63'd0, o_sat}, 64'd0);

      // Coefficient write on the sample edge applies only to later samples
      i_coef_we = 1'b1;
      i_coef    = 32'h02E2_A8ED;
      send(32'h0058_B90C, 32'h00B1_7218, 1'b1);
      i_coef_we = 1'b0;
      coef_m    = 32'h02E2_A8ED;
      send(32'h0058_B90C, model(32'h0058_B90C, coef_m), 1'b1);
      wait_idle("log2");

      // Rounding boundary: +half rounds up, -half rounds to zero
      write_coef(32'h0080_0000);
      send(32'h0000_0001, 32'h0000_0001, 1'b1);
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      wait_idle("round");
      check_eq("sat_round", {63'd0, o_sat}, 64'd0);

      // Saturation both ways, then flag clear
      write_coef(32'h7FFF_FFFF);
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
      wait_idle("sat_pos");
      check_eq("sat_set", {63'd0, o_sat}, 64'd1);
      write_coef(32'h8000_0000);
      send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      wait_idle("sat_neg");
      clear_flags();
      check_eq("sat_clr", {63'd0, o_sat}, 64'd0);

      // Back-to-back random samples with random coefficients
      for (int r = 0; r < 3; r++) begin
         c = $urandom();
         if (r == 0) c = {{8{c[31]}}, c[23:0]};
         write_coef(c);
         for (int i = 0; i < 8; i++) begin
            d = $urandom();
            send(d, model(d, coef_m), 1'b1);
         end
      end
      wait_idle("random");
      clear_flags();

      // Overflow: six samples into a stalled FIFO, first four kept
      write_coef(32'h0200_0000);
      i_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d = 32'h0010_0000 * (i + 1);
         send(d, model(d, coef_m), i < 4);
      end
      for (int i = 0; i < 3; i++) tick();
      check_eq("ovf_count", {61'd0, o_count}, 64'd4);
      check_eq("ovf_flag", {63'd0, o_overflow}, 64'd1);
      i_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge i_clk);
         check_eq($sformatf("drain_%0d", k), {63'd0, o_valid}, {63'd0, (k < 4)});
         tick();
      end
      check_eq("drain_count", {61'd0, o_count}, 64'd0);

      // Simultaneous read and write at full
      clear_flags();
      check_eq("ovf_clr", {63'd0, o_overflow}, 64'd0);
      i_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = 32'hFF00_0000 + 32'h0003_0000 * i;
         send(d, model(d, coef_m), 1'b1);
      end
      for (int i = 0; i < 3; i++) tick();
      check_eq("full_count", {61'd0, o_count}, 64'd4);
      send(32'h0123_4567, model(32'h0123_4567, coef_m), 1'b1);
      tick();
      i_ready = 1'b1;
      tick();
      i_ready = 1'b0;
      check_eq("rw_full_count", {61'd0, o_count}, 64'd4);
      check_eq("rw_full_ovf", {63'd0, o_overflow}, 64'd0);
      i_ready = 1'b1;
      wait_idle("rw_drain");

      // Asynchronous reset mid-stream clears everything, coef back to 2.0
      write_coef(32'h0100_0000);
      i_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(32'h0040_0000, 32'h0, 1'b0);
      #3;
      i_arstn = 1'b0;
      #1;
      check_eq("mid_rst_valid", {63'd0, o_valid}, 64'd0);
      check_eq("mid_rst_data", {32'd0, o_data}, 64'd0);
      check_eq("mid_rst_count", {61'd0, o_count}, 64'd0);
      check_eq("mid_rst_ovf", {63'd0, o_overflow}, 64'd0);
      exp_q.delete();
      tick();
      i_arstn = 1'b1;
      tick();
      i_ready = 1'b1;
      send(32'h0058_B90C, 32'h00B1_7218, 1'b1);
      wait_idle("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cordic_log_scale.md
Name: cordic_log_scale

Overview:
- Downstream companion to the CORDIC natural-log pipeline.
- The log core emits fix32_24 L = ln(x)/2. This block multiplies L by a programmable fix32_24 coefficient C (2.0 gives ln, 2/ln(m) gives log base m).
- It rounds and saturates the result, then buffers it in a small FIFO with a valid/ready output, because the upstream log pipeline has no backpressure.

Parameters:
- DEPTH, 4, output FIFO depth in words; power of two, ≥2.
- COEF_RST, 32'h0200_0000, coefficient reset value (2.0, giving natural log).

Ports:
- i_clk  input  1  clock.
- i_arstn  input  1  asynchronous active-low reset.
- i_valid  input  1  input sample strobe; no backpressure, always accepted.
- i_data  input  32  signed fix32_24 input (log-core output).
- i_coef_we  input  1  coefficient write strobe.
- i_coef  input  32  signed fix32_24 coefficient.
- i_flag_clr  input  1  clears the sticky flags.
- o_valid  output  1  FIFO non-empty.
- i_ready  input  1  consumer accept.
- o_data  output  32  signed fix32_24 result at FIFO head.
- o_overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.
- o_sat  output  1  sticky flag: a result saturated.
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset: reset is i_arstn, asynchronous, active-low; clock is i_clk. All registers clear: coef = COEF_RST, pipeline valids 0, FIFO pointers 0, storage 0, o_valid 0, o_data 0, o_overflow 0, o_sat 0, o_count 0. Reset mid-operation discards all in-flight and buffered samples.
- Coefficient register:
  - Written on any clock edge with i_coef_we = 1.
  - A sample is scaled by the coef value registered at the edge where that sample enters stage 1.
  - A write on the same edge as i_valid does not apply to that sample; it applies from the next sample on.
- Stage 1 (edge N, when i_valid = 1): p1 = signed(i_data) × signed(coef), full 64-bit product (Q16.48); v1 = 1.
- Stage 2 (edge N+1, when v1 = 1):
  - r = (p1 + 2^23) >>> 24 (round half up, arithmetic shift).
  - If r > 2^31−1, result = 32'h7FFF_FFFF. If r < −2^31, result = 32'h8000_0000. Otherwise result = r[31:0].
  - If either clamp occurs, set o_sat.
  - Attempt a FIFO write.
- Latency: a result is visible at o_data with o_valid = 1 from the cycle after edge N+2 when the FIFO was empty. The pipeline accepts one sample per clock.
- FIFO:
  - DEPTH words. o_data = storage[rd_ptr], combinational from registers. o_valid = (count ≠ 0).
  - Read occurs when o_valid & i_ready at an edge.
  - A write while full with no read in the same cycle drops the sample and sets o_overflow. FIFO contents are unchanged.
  - Simultaneous read and write when full: both occur, nothing is dropped, count unchanged.
  - Simultaneous read and write when empty: the write proceeds, the read is ignored (o_valid was 0).
  - Pointers wrap modulo DEPTH. o_count ranges 0..DEPTH.
- Sticky flags:
  - Cleared by i_flag_clr.
  - If a set event and i_flag_clr occur on the same edge, set wins.
- i_ready while empty: no effect.

Test Plan:
- Default coef (2.0), i_data = 32'h0058_B90C, i_ready = 1 → o_data = 32'h00B1_7218 (ln 2) with o_valid high for exactly 1 cycle, 2 edges after input; o_sat = 0.
- Write i_coef = 32'h02E2_A8ED (2/ln2), then i_data = 32'h0058_B90C → o_data = 32'h0100_0000 (log2(2) = 1.0).
- Rounding boundary: coef = 32'h0080_0000 (0.5), i_data = 32'h0000_0001 → o_data = 32'h0000_0001. Then i_data = 32'hFFFF_FFFF → o_data = 32'h0000_0000.
- Saturation:
  - coef = 32'h7FFF_FFFF, i_data = 32'h7FFF_FFFF → o_data = 32'h7FFF_FFFF, o_sat = 1.
  - coef = 32'h8000_0000, same data → o_data = 32'h8000_0000.
  - i_flag_clr then clears o_sat to 0.
- Backpressure/overflow, DEPTH = 4:
  - With i_ready = 0, stream 6 consecutive samples → o_count = 4, the first 4 results retained in order, o_overflow = 1.
  - Then i_ready = 1 → 4 results drain on consecutive cycles, o_count reaches 0.
- Simultaneous read/write at full, and reset mid-stream:
  - At full, one read and one write on the same edge → o_count stays 4, o_overflow unchanged.
  - Assert i_arstn = 0 mid-stream → all outputs 0 immediately; coef back to 2.0.
